// File: rtl/motor_edge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : motor_edge_pkg
// Description : Shared types and defaults for the motor edge detector.
//               edge_mode_t encodes the per-channel edge select, and
//               edge_match() tells whether a level transition is wanted.
// Revision    : 1.0 - initial release
// ============================================================================
package motor_edge_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_t;

    localparam int c_DEB_CYCLES_DEF = 4;
    localparam int c_CNT_W_DEF      = 16;
    // Stability counter width; large enough for DEB_CYCLES up to 255.
    localparam int c_STAB_W         = 8;

    // True when a transition to new_level is selected by mode m.
    function automatic logic edge_match(input edge_mode_t m, input logic new_level);
        logic w_hit;
        case (m)
            EDGE_RISE: w_hit = new_level;
            EDGE_FALL: w_hit = ~new_level;
            EDGE_BOTH: w_hit = 1'b1;
            default:   w_hit = 1'b0;
        endcase
        return w_hit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/motor_edge_chan.sv
`default_nettype none
// ============================================================================
// Module      : motor_edge_chan
// Description : One sense channel: 2-flop synchroniser, optional debounce
//               filter, edge detector with one-cycle event pulse, and a
//               wrapping event counter.
//               Macro MOTOR_EDGE_DEBOUNCE_EN builds the debounce filter;
//               without it the level follows the synchroniser directly.
// Ports       : clk, rst (async, active-low), i_sense (raw input),
//               i_mode (edge select), i_cnt_clr (sync counter clear),
//               o_level (accepted level), o_e (event pulse),
//               o_cnt (event counter)
// Revision    : 1.0 - initial release
// ============================================================================
module motor_edge_chan
    import motor_edge_pkg::*;
#(
    parameter int DEB_CYCLES = c_DEB_CYCLES_DEF,
    parameter int CNT_W      = c_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_sense,
    input  logic [1:0]       i_mode,
    input  logic             i_cnt_clr,
    output logic             o_level,
    output logic             o_e,
    output logic [CNT_W-1:0] o_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [1:0]       r_sync;
    logic [1:0]       r_vld;    // marks when r_sync[1] holds a real sample
    logic             r_prime;
    logic             r_level;
    logic             r_e;
    logic [CNT_W-1:0] r_cnt;

    logic       w_sync;
    logic       w_prime_now;
    edge_mode_t w_mode;

    assign w_sync      = r_sync[1];
    assign w_prime_now = r_prime & r_vld[1];
    assign w_mode      = edge_mode_t'(i_mode);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= 2'b00;
            r_vld  <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_sense};
            r_vld  <= {r_vld[0], 1'b1};
        end
    end

`ifdef MOTOR_EDGE_DEBOUNCE_EN
    localparam logic [c_STAB_W-1:0] c_STAB_LAST = c_STAB_W'(DEB_CYCLES - 1);
    localparam logic [c_STAB_W-1:0] c_STAB_ONE  = c_STAB_W'(1);

    logic [c_STAB_W-1:0] r_stab;
    logic                r_chg;     // level changed on the previous edge

    // The pulse is raised one cycle after the level moves, with mode
    // sampled while the new level is visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prime <= 1'b1;
            r_level <= 1'b0;
            r_stab  <= '0;
            r_chg   <= 1'b0;
            r_e     <= 1'b0;
        end else begin
            r_chg <= 1'b0;
            r_e   <= r_chg & edge_match(w_mode, r_level);
            if (w_prime_now) begin
                r_prime <= 1'b0;
                r_level <= w_sync;
                r_stab  <= '0;
            end else if (!r_prime) begin
                if (w_sync != r_level) begin
                    if (r_stab == c_STAB_LAST) begin
                        r_level <= w_sync;
                        r_stab  <= '0;
                        r_chg   <= 1'b1;
                    end else begin
                        r_stab <= r_stab + c_STAB_ONE;
                    end
                end else begin
                    // Any return to the accepted level restarts the count.
                    r_stab <= '0;
                end
            end
        end
    end
`else
    // Level is a single register behind the synchroniser; the pulse is
    // registered on the same edge so it appears at the third edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prime <= 1'b1;
            r_level <= 1'b0;
            r_e     <= 1'b0;
        end else begin
            r_e <= 1'b0;
            if (w_prime_now) begin
                r_prime <= 1'b0;
                r_level <= w_sync;
            end else if (!r_prime) begin
                r_level <= w_sync;
                r_e     <= (w_sync != r_level) & edge_match(w_mode, w_sync);
            end
        end
    end
`endif

    // Counter runs off the registered pulse, so a clear in the pulse
    // cycle still keeps that event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_cnt_clr) begin
            r_cnt <= r_e ? c_CNT_ONE : '0;
        end else if (r_e) begin
            r_cnt <= r_cnt + c_CNT_ONE;
        end
    end

    assign o_level = r_level;
    assign o_e     = r_e;
    assign o_cnt   = r_cnt;

endmodule
`default_nettype wire

// File: rtl/motor_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : motor_edge_detect
// Description : Multi-channel motor sense edge detector. Each channel is an
//               independent motor_edge_chan instance.
//               Macro MOTOR_EDGE_DEBOUNCE_EN enables the debounce filter.
// Ports       : clk, rst (async, active-low), sense[N_CH], mode[2*N_CH],
//               cnt_clr, level[N_CH], e[N_CH], cnt[N_CH*CNT_W]
// Revision    : 1.0 - initial release
// ============================================================================
module motor_edge_detect
    import motor_edge_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int DEB_CYCLES = c_DEB_CYCLES_DEF,
    parameter int CNT_W      = c_CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       sense,
    input  logic [2*N_CH-1:0]     mode,
    input  logic                  cnt_clr,
    output logic [N_CH-1:0]       level,
    output logic [N_CH-1:0]       e,
    output logic [N_CH*CNT_W-1:0] cnt
);

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
        motor_edge_chan #(
            .DEB_CYCLES (DEB_CYCLES),
            .CNT_W      (CNT_W)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .i_sense   (sense[gi]),
            .i_mode    (mode[2*gi +: 2]),
            .i_cnt_clr (cnt_clr),
            .o_level   (level[gi]),
            .o_e       (e[gi]),
            .o_cnt     (cnt[gi*CNT_W +: CNT_W])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_motor_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : tb_motor_edge_detect
// Description : Directed self-checking bench for motor_edge_detect with
//               N_CH=4, DEB_CYCLES=4, CNT_W=4. Adapts its latency to the
//               MOTOR_EDGE_DEBOUNCE_EN build option.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_motor_edge_detect;

    localparam int c_N_CH  = 4;
    localparam int c_DEB   = 4;
    localparam int c_CNT_W = 4;
`ifdef MOTOR_EDGE_DEBOUNCE_EN
    localparam int c_LAT = 2 + c_DEB + 1;
`else
    localparam int c_LAT = 3;
`endif

    logic        clk;
    logic        rst;
    logic [3:0]  sense;
    logic [7:0]  mode;
    logic        cnt_clr;
    logic [3:0]  level;
    logic [3:0]  e;
    logic [15:0] cnt;

    logic [3:0]  s;
    int          n_vec;
    int          n_bad;

    motor_edge_detect #(
        .N_CH       (c_N_CH),
        .DEB_CYCLES (c_DEB),
        .CNT_W      (c_CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sense   (sense),
        .mode    (mode),
        .cnt_clr (cnt_clr),
        .level   (level),
        .e       (e),
        .cnt     (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Step ncyc edges; e must equal emask at edge number hit, else 0.
    task automatic watch(input string tag, input int ncyc, input int hit, input logic [3:0] emask);
        for (int k = 1; k <= ncyc; k++) begin
            step(1);
            chk(tag, 32'(e), (k == hit) ? 32'(emask) : 32'h0);
        end
    endtask

    initial begin
        n_vec   = 0;
        n_bad   = 0;
        rst     = 1'b1;
        s       = 4'b0001;
        sense   = s;
        mode    = 8'hFF;
        cnt_clr = 1'b0;

        // Asynchronous reset before any clock edge.
        #2 rst = 1'b0;
        #1;
        chk("rst_level", 32'(level), 32'h0);
        chk("rst_e",     32'(e),     32'h0);
        chk("rst_cnt",   32'(cnt),   32'h0);
        step(3);
        rst = 1'b1;

        // Channel 0 held high through reset: primes, no event.
        watch("prime_e", 20, 0, 4'h0);
        chk("prime_level", 32'(level), 32'h1);
        chk("prime_cnt",   32'(cnt),   32'h0);

        // Channel 0 fall then rise, both edges selected.
        s[0] = 1'b0; sense = s;
        watch("ch0_fall_e", c_LAT + 1, c_LAT, 4'h1);
        chk("ch0_fall_level", 32'(level), 32'h0);
        chk("ch0_fall_cnt",   32'(cnt),   32'h0001);
        s[0] = 1'b1; sense = s;
        watch("ch0_rise_e", c_LAT + 1, c_LAT, 4'h1);
        chk("ch0_rise_level", 32'(level), 32'h1);
        chk("ch0_rise_cnt",   32'(cnt),   32'h0002);

`ifdef MOTOR_EDGE_DEBOUNCE_EN
        // Channel 1 rising-only; 3-cycle glitch is filtered.
        mode = 8'hF7;
        s[1] = 1'b1; sense = s;
        step(3);
        s[1] = 1'b0; sense = s;
        watch("glitch_e", 10, 0, 4'h0);
        chk("glitch_level", 32'(level), 32'h1);
        // 5-cycle pulse: rise accepted, fall suppressed by mode.
        s[1] = 1'b1; sense = s;
        for (int k = 1; k <= 15; k++) begin
            step(1);
            if (k == 5) begin
                s[1] = 1'b0; sense = s;
            end
            chk("pulse5_e", 32'(e), (k == 7) ? 32'h2 : 32'h0);
        end
        chk("pulse5_level", 32'(level), 32'h1);
        chk("pulse5_cnt",   32'(cnt),   32'h0012);
        mode = 8'hFF;
`else
        // Channel 3 change seen at the third edge.
        s[3] = 1'b1; sense = s;
        watch("ch3_e", 4, 3, 4'h8);
        chk("ch3_level", 32'(level), 32'h9);
        // One-cycle low pulse gives a fall and a rise event.
        s[3] = 1'b0; sense = s;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            if (k == 1) begin
                s[3] = 1'b1; sense = s;
            end
            chk("ch3_narrow_e", 32'(e), (k == 3 || k == 4) ? 32'h8 : 32'h0);
        end
        chk("ch3_narrow_cnt", 32'(cnt), 32'h3002);
        // Clear so both builds share the following expectations.
        cnt_clr = 1'b1;
        step(1);
        cnt_clr = 1'b0;
        cnt_clr = 1'b0;
        chk("clr_cnt", 32'(cnt), 32'h0);
        s[3] = 1'b0; sense = s;
        mode = 8'h3F;
        watch("ch3_off_e", 5, 0, 4'h0);
        mode = 8'hFF;
        // Re-create the counts of the debounce path (ch0=2, ch1=1).
        s[0] = 1'b0; sense = s; step(c_LAT + 1);
        s[0] = 1'b1; sense = s; step(c_LAT + 1);
        s[1] = 1'b1; sense = s; step(c_LAT + 1);
        s[1] = 1'b0; sense = s; mode = 8'hF7; step(c_LAT + 1);
        mode = 8'hFF;
        chk("ch01_cnt", 32'(cnt), 32'h0012);
`endif

        // Channel 2 disabled: level moves, no pulse, no count.
        mode = 8'hCF;
        s[2] = 1'b1; sense = s;
        watch("off_e", c_LAT + 2, 0, 4'h0);
        chk("off_level", 32'(level), 32'h5);
        chk("off_cnt",   32'(cnt),   32'h0012);

        // 16 toggles on channel 2 wrap its 4-bit counter.
        mode = 8'hFF;
        for (int t = 1; t <= 16; t++) begin
            s[2] = ~s[2]; sense = s;
            step(c_LAT + 1);
            if (t == 15) chk("wrap15_cnt", 32'(cnt), 32'h0F12);
        end
        chk("wrap_cnt", 32'(cnt), 32'h0012);
        for (int t = 1; t <= 2; t++) begin
            s[2] = ~s[2]; sense = s;
            step(c_LAT + 1);
        end
        chk("pre_clr_cnt", 32'(cnt), 32'h0212);

        // Clear coincident with a channel 2 pulse keeps that event.
        s[2] = ~s[2]; sense = s;
        step(c_LAT);
        chk("clr_pulse_e", 32'(e), 32'h4);
        cnt_clr = 1'b1;
        step(1);
        cnt_clr = 1'b0;
        chk("clr_pulse_cnt", 32'(cnt), 32'h0100);

        // All channels toggle together.
        s = ~s; sense = s;
        watch("all_e", c_LAT + 1, c_LAT, 4'hF);
        chk("all_level", 32'(level), 32'(s));
        chk("all_cnt",   32'(cnt),   32'h1211);

        // Reset two cycles into a pending transition.
        s[0] = ~s[0]; sense = s;
        step(2);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_level", 32'(level), 32'h0);
        chk("mid_rst_e",     32'(e),     32'h0);
        chk("mid_rst_cnt",   32'(cnt),   32'h0);
        step(3);
        rst = 1'b1;
        watch("post_rst_e", 15, 0, 4'h0);
        chk("post_rst_level", 32'(level), 32'(s));
        chk("post_rst_cnt",   32'(cnt),   32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
